// File: rtl/encoder_frame_tx.sv
// Encoder-side serial frame transmitter: low start bit, FRAME_W bits MSB-first, then a high idle gap.
// Latency: the start bit appears in the cycle after accept, and the frame bits follow in the next FRAME_W cycles.
// Backpressure: pos_ready is high only in IDLE; pos_valid outside IDLE is ignored, with no queueing. Optional parity: ENC_TX_PARITY_EN.
module encoder_frame_tx #(
  parameter int FRAME_W    = 24,
  parameter int POS_W      = 19,
  parameter int POS_LSB    = 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic             sck,
  input  logic             rst_n,
  input  logic [POS_W-1:0] pos_in,
  input  logic [1:0]       status_in,
  input  logic             pos_valid,
  output logic             pos_ready,
  output logic             miso,
  output logic             busy,
  output logic             frame_done
);

  // The bit counter only has to reach FRAME_W-1, and the gap counter only GAP_CYCLES-1.
  localparam int CW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:1] frame_body;
  logic               frame_par;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               miso_d;
  logic               done_d;
  logic               accept;

  assign pos_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = pos_valid && pos_ready;

  // Assemble the frame body: zero pad above the position field, then position, then {err, warn}.
  always_comb begin
    frame_body                            = '0;
    frame_body[POS_LSB +: POS_W]          = pos_in;
    frame_body[2:1]                       = status_in;
  end

`ifdef ENC_TX_PARITY_EN
  // The parity bit makes the whole frame even parity.
  assign frame_par = ^frame_body;
`else
  assign frame_par = 1'b0;
`endif

  // Next-state logic. miso and frame_done are computed for the next state,
  // so the registered outputs line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    miso_d  = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          frame_d = {frame_body, frame_par};
          miso_d  = 1'b0;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = CW'(FRAME_W - 1);
        miso_d  = frame_q[FRAME_W-1];
      end
      DATA: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          gap_d   = GW'(GAP_CYCLES - 1);
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q - CW'(1);
          miso_d = frame_q[cnt_d];
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset drives the line idle immediately, even mid-frame.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      miso       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      miso       <= miso_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_encoder_frame_tx.sv
// Bench for encoder_frame_tx: a cycle-phase reference model plus a serial receiver feeding a scoreboard.
// Latency: expected line levels are derived from the number of sck edges since the accept.
// Backpressure: the model accepts only when it is idle, so valid pulses during a busy frame must not push a frame.
module tb_encoder_frame_tx;

  localparam int FRAME_W    = 24;
  localparam int POS_W      = 19;
  localparam int POS_LSB    = 3;
  localparam int GAP_CYCLES = 4;
  localparam int LAST_PH    = FRAME_W + 1 + GAP_CYCLES;

`ifdef ENC_TX_PARITY_EN
  localparam logic [FRAME_W-1:0] EXP_A = 24'h2D2D2D;
  localparam logic [FRAME_W-1:0] EXP_B = 24'h3FFFF9;
`else
  localparam logic [FRAME_W-1:0] EXP_A = 24'h2D2D2C;
  localparam logic [FRAME_W-1:0] EXP_B = 24'h3FFFF8;
`endif

  typedef struct packed {
    logic [FRAME_W-1:0] frame;
    logic [POS_W-1:0]   pos;
  } exp_t;

  logic             sck = 1'b0;
  logic             rst_n = 1'b0;
  logic [POS_W-1:0] pos_in = '0;
  logic [1:0]       status_in = '0;
  logic             pos_valid = 1'b0;
  logic             pos_ready, miso, busy, frame_done;

  int total = 0;
  int bad = 0;

  exp_t               sb_q[$];
  int                 phase = 0;
  logic [FRAME_W-1:0] cur_frame = '0;

  logic               rx_active = 1'b0;
  int                 rx_cnt = 0;
  logic [FRAME_W-1:0] rx_shift = '0;
  logic [FRAME_W-1:0] last_rx = '0;
  int                 hi_run = 0;
  int                 last_gap = 0;
  int                 rx_frames = 0;

  always #5 sck = ~sck;

  encoder_frame_tx #(
    .FRAME_W(FRAME_W), .POS_W(POS_W), .POS_LSB(POS_LSB), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .sck(sck), .rst_n(rst_n), .pos_in(pos_in), .status_in(status_in),
    .pos_valid(pos_valid), .pos_ready(pos_ready), .miso(miso),
    .busy(busy), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FRAME_W-1:0] build_frame(input logic [POS_W-1:0] p, input logic [1:0] s);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[POS_LSB +: POS_W] = p;
    f[2:1] = s;
`ifdef ENC_TX_PARITY_EN
    f[0] = ^f;
`endif
    return f;
  endfunction

  // Reference model: phase counts sck edges since accept; 0 means idle.
  always @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0;
      sb_q.delete();
    end else if (phase == 0) begin
      if (pos_valid) begin
        phase     <= 1;
        cur_frame <= build_frame(pos_in, status_in);
        sb_q.push_back({build_frame(pos_in, status_in), pos_in});
      end
    end else if (phase == LAST_PH) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
    end
  end

  // Per-cycle output check, sampled mid-cycle.
  always @(negedge sck) begin : cyc_chk
    logic exp_miso;
    if (rst_n) begin
      if (phase == 0)                exp_miso = 1'b1;
      else if (phase == 1)           exp_miso = 1'b0;
      else if (phase <= FRAME_W + 1) exp_miso = cur_frame[FRAME_W + 1 - phase];
      else                           exp_miso = 1'b1;
      chk("miso", 32'(miso), 32'(exp_miso));
      chk("busy", 32'(busy), 32'(phase != 0));
      chk("pos_ready", 32'(pos_ready), 32'(phase == 0));
      chk("frame_done", 32'(frame_done), 32'(phase == FRAME_W + 2));
    end
  end

  // Link receiver: hunt for the start bit, shift FRAME_W bits, and compare against the scoreboard.
  always @(negedge sck) begin : rx_blk
    logic [FRAME_W-1:0] w;
    exp_t               e;
    if (!rst_n) begin
      rx_active <= 1'b0;
      rx_cnt    <= 0;
      hi_run    <= 0;
    end else if (!rx_active) begin
      if (miso == 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 0;
        last_gap  <= hi_run;
      end else begin
        hi_run <= hi_run + 1;
      end
    end else begin
      w = {rx_shift[FRAME_W-2:0], miso};
      rx_shift <= w;
      if (rx_cnt == FRAME_W - 1) begin
        if (sb_q.size() == 0) begin
          chk("rx_unexpected", 32'(1), 32'(0));
        end else begin
          e = sb_q.pop_front();
          chk("rx_frame", 32'(w), 32'(e.frame));
          chk("rx_pos", 32'(w[POS_LSB +: POS_W]), 32'(e.pos));
        end
        last_rx   <= w;
        rx_frames <= rx_frames + 1;
        rx_active <= 1'b0;
        hi_run    <= 0;
      end else begin
        rx_cnt <= rx_cnt + 1;
      end
    end
  end

  task automatic wait_phase(input int p, input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge sck);
      if (phase == p) return;
    end
    chk({tag, "_timeout"}, 32'(1), 32'(0));
  endtask

  task automatic send(input logic [POS_W-1:0] p, input logic [1:0] s);
    wait_phase(0, "send_idle");
    #1;
    pos_in    = p;
    status_in = s;
    pos_valid = 1'b1;
    @(negedge sck);
    #1;
    pos_valid = 1'b0;
  endtask

  initial begin
    int base;

    // Reset state, before and without any release.
    #12;
    chk("rst_miso", 32'(miso), 32'(1));
    chk("rst_ready", 32'(pos_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(frame_done), 32'(0));
    @(negedge sck);
    #1 rst_n = 1'b1;

    // Idle line with no valid.
    repeat (50) @(negedge sck);
    chk("idle_miso", 32'(miso), 32'(1));
    chk("idle_frames", 32'(rx_frames), 32'(0));

    // Directed frame.
    send(19'h5A5A5, 2'b10);
    wait_phase(0, "a_done");
    chk("a_frame", 32'(last_rx), 32'(EXP_A));
    chk("a_count", 32'(rx_frames), 32'(1));

    // Back-to-back frames with valid held high.
    wait_phase(0, "b_idle");
    #1;
    pos_in    = '0;
    status_in = 2'b00;
    pos_valid = 1'b1;
    @(negedge sck);
    #1 pos_in = 19'h7FFFF;
    wait_phase(0, "b_second");
    @(negedge sck);
    #1 pos_valid = 1'b0;
    wait_phase(0, "b_done");
    chk("b_frame", 32'(last_rx), 32'(EXP_B));
    chk("b_gap", 32'(last_gap), 32'(GAP_CYCLES + 1));
    chk("b_count", 32'(rx_frames), 32'(3));

    // Inputs churn and valid pulses during the frame.
    base = rx_frames;
    send(19'h12345, 2'b01);
    for (int i = 0; i < 28; i++) begin
      @(negedge sck);
      #1;
      pos_in    = 19'($urandom);
      status_in = 2'($urandom);
      pos_valid = ((i % 7) == 3);
    end
    pos_valid = 1'b0;
    wait_phase(0, "t_done");
    chk("t_frame", 32'(last_rx), 32'(build_frame(19'h12345, 2'b01)));
    chk("t_count", 32'(rx_frames), 32'(base + 1));

    // Async reset while frame bit 10 is on the line.
    base = rx_frames;
    send(19'h55555, 2'b11);
    wait_phase(2 + FRAME_W - 1 - 10, "r_bit10");
    chk("r_pre_miso", 32'(miso), 32'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("r_miso", 32'(miso), 32'(1));
    chk("r_busy", 32'(busy), 32'(0));
    chk("r_ready", 32'(pos_ready), 32'(1));
    repeat (2) @(negedge sck);
    #1 rst_n = 1'b1;
    send(19'h0F0F0, 2'b01);
    wait_phase(0, "r_done");
    chk("r_fresh", 32'(last_rx), 32'(build_frame(19'h0F0F0, 2'b01)));
    chk("r_count", 32'(rx_frames), 32'(base + 1));

    // Random loopback.
    base = rx_frames;
    for (int i = 0; i < 100; i++) begin
      send(19'($urandom), 2'($urandom));
    end
    wait_phase(0, "rnd_done");
    chk("rnd_count", 32'(rx_frames), 32'(base + 100));
    chk("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
